// File: rtl/sa_ack_root_if.sv
// ---------------------------------------------------------------------------
// sa_ack_root_if
// Bundle between the switch-allocator leaves and the root responder.
//
//   req         leaf -> root   aggregated request from each leaf (level)
//   credit_ret  leaf -> root   one resource credit returned (pulse per credit)
//   ack         root -> leaf   registered one-hot-or-zero acknowledge
//   credit_cnt  root -> leaf   credits currently available at the root
//   busy        root -> leaf   root is granting or stalled on credits
//   cred_err    root -> leaf   sticky: a credit came back while the pool was full
//
// master modport is the leaf side, slave modport is the root side.
// ---------------------------------------------------------------------------
interface sa_ack_root_if #(
    parameter int N_CHILD = 4,
    parameter int CREDITS = 4
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [N_CHILD-1:0] req;
    logic [N_CHILD-1:0] ack;
    logic               credit_ret;
    logic [CW-1:0]      credit_cnt;
    logic               busy;
    logic               cred_err;

    modport master (
        output req,
        output credit_ret,
        input  ack,
        input  credit_cnt,
        input  busy,
        input  cred_err
    );

    modport slave (
        input  req,
        input  credit_ret,
        output ack,
        output credit_cnt,
        output busy,
        output cred_err
    );
endinterface

// File: rtl/sa_ack_root.sv
// ---------------------------------------------------------------------------
// sa_ack_root
// Root responder of the switch-allocator request tree. Each cycle it picks at
// most one requesting leaf, returns a registered one-hot ack to it and spends
// one downstream credit. Credits come back one per credit_ret pulse.
// Arbitration is round-robin; the current owner may be held for up to
// HOLD_MAX consecutive acks while it keeps requesting, after which the
// round-robin scan takes over again.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   sa_ack_root_if.slave : req, credit_ret in; ack, credit_cnt,
//         busy, cred_err out
//
// Parameters
//   N_CHILD   number of leaf allocators (>=2)
//   CREDITS   credits available after reset (>=1)
//   HOLD_MAX  max consecutive acks to one owner while it is kept (>=1)
// ---------------------------------------------------------------------------
module sa_ack_root #(
    parameter int N_CHILD  = 4,
    parameter int CREDITS  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    sa_ack_root_if.slave  bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
    localparam int HW = $clog2(HOLD_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]         r_state;
    logic [N_CHILD-1:0] r_ack;
    logic [CW-1:0]      r_creditCnt;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [HW-1:0]      r_holdCnt;
    logic               r_credErr;

    logic               w_reqAny;
    logic               w_canGo;
    logic               w_keep;
    logic               w_scanFound;
    logic [PW-1:0]      w_scanSel;
    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_selNext;
    logic [N_CHILD-1:0] w_selOneHot;
    logic               w_creditFull;
    logic               w_creditRetOk;
    logic [CW-1:0]      w_creditNext;
    logic [1:0]         w_stateNext;

    assign w_reqAny      = |bus.req;
    assign w_canGo       = (r_creditCnt != '0) && w_reqAny;
    assign w_creditFull  = (r_creditCnt == CW'(CREDITS));
    assign w_creditRetOk = bus.credit_ret && !w_creditFull;

    // The owner is kept only while it is still acked, still requesting and
    // has not used up its hold budget.
    assign w_keep = (r_state == ST_GRANT) && bus.req[r_owner] &&
                    (r_holdCnt < HW'(HOLD_MAX));

    // Round-robin scan: first requester at or after r_ptr, wrapping. The sum
    // of pointer and offset stays below 2*N_CHILD, so one subtraction wraps it.
    always_comb begin
        logic [PW:0] idx;
        w_scanFound = 1'b0;
        w_scanSel   = r_ptr;
        for (int k = 0; k < N_CHILD; k++) begin
            idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N_CHILD)) begin
                idx = idx - (PW+1)'(N_CHILD);
            end
            if (!w_scanFound && bus.req[idx[PW-1:0]]) begin
                w_scanFound = 1'b1;
                w_scanSel   = idx[PW-1:0];
            end
        end
    end

    assign w_sel     = w_keep ? r_owner : w_scanSel;
    assign w_selNext = (w_sel == PW'(N_CHILD - 1)) ? '0 : (w_sel + PW'(1));

    always_comb begin
        w_selOneHot        = '0;
        w_selOneHot[w_sel] = 1'b1;
    end

    // Consume and return in the same cycle cancel out; a return into a full
    // pool is ignored so the count saturates at CREDITS.
    always_comb begin
        w_creditNext = r_creditCnt;
        if (w_canGo && !w_creditRetOk) begin
            w_creditNext = r_creditCnt - CW'(1);
        end else if (!w_canGo && w_creditRetOk) begin
            w_creditNext = r_creditCnt + CW'(1);
        end
    end

    // The state tracks what the ack register will hold: granting when an ack
    // is issued, stalled when requests wait without credit, idle otherwise.
    // Every state uses the same decision, so STALL resumes the cycle a credit
    // shows up in the register.
    always_comb begin
        w_stateNext = ST_IDLE;
        if (w_canGo) begin
            w_stateNext = ST_GRANT;
        end else if (w_reqAny) begin
            w_stateNext = ST_STALL;
        end
    end

    // Registered state, ack and credit pool. Reset also forgets any
    // outstanding credits by reloading the full pool.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ack       <= '0;
            r_creditCnt <= CW'(CREDITS);
            r_credErr   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_ack       <= w_canGo ? w_selOneHot : '0;
            r_creditCnt <= w_creditNext;
            if (bus.credit_ret && w_creditFull) begin
                r_credErr <= 1'b1;
            end
        end
    end

    // Ownership bookkeeping only moves when an ack is actually issued. A kept
    // owner extends its hold; any other selection (including the owner picked
    // again by the scan as sole requester) starts a fresh hold and moves the
    // round-robin pointer past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_holdCnt <= '0;
        end else if (w_canGo) begin
            if (w_keep) begin
                r_holdCnt <= r_holdCnt + HW'(1);
            end else begin
                r_owner   <= w_sel;
                r_holdCnt <= HW'(1);
                r_ptr     <= w_selNext;
            end
        end
    end

    assign bus.ack        = r_ack;
    assign bus.credit_cnt = r_creditCnt;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.cred_err   = r_credErr;

endmodule

// File: tb/tb_sa_ack_root.sv
// ---------------------------------------------------------------------------
// tb_sa_ack_root
// Drives two roots from the same leaf stimulus: one with the default pool
// (4 credits, hold 8) and one with a deep pool and short hold (16 credits,
// hold 2). A behavioural model of each root is stepped on every rising edge
// and every output is compared against it on the falling edge. Directed
// sequences pin both DUT and model to hand-computed values, then a random
// run exercises the general case.
// ---------------------------------------------------------------------------
module tb_sa_ack_root;

    typedef struct {
        int cnt;
        int owner;
        int hold;
        int ptr;
        bit acked;
        int ackIdx;
        bit pending;
        bit err;
    } model_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] reqDrive;
    logic       retDrive;

    int testsRun    = 0;
    int testsFailed = 0;

    model_t mA;
    model_t mB;

    always #5 clk = ~clk;

    sa_ack_root_if #(.N_CHILD(4), .CREDITS(4))  busA ();
    sa_ack_root_if #(.N_CHILD(4), .CREDITS(16)) busB ();

    assign busA.req        = reqDrive;
    assign busA.credit_ret = retDrive;
    assign busB.req        = reqDrive;
    assign busB.credit_ret = retDrive;

    sa_ack_root #(.N_CHILD(4), .CREDITS(4), .HOLD_MAX(8)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    sa_ack_root #(.N_CHILD(4), .CREDITS(16), .HOLD_MAX(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    function automatic model_t modelReset(int credits);
        model_t s;
        s.cnt     = credits;
        s.owner   = 0;
        s.hold    = 0;
        s.ptr     = 0;
        s.acked   = 1'b0;
        s.ackIdx  = 0;
        s.pending = 1'b0;
        s.err     = 1'b0;
        return s;
    endfunction

    // One clock of root behaviour: keep the owner if it is still acked,
    // requesting and under its hold budget, otherwise take the first
    // requester walking forward from the pointer.
    function automatic model_t modelStep(model_t s, logic [3:0] req, logic ret,
                                         int credits, int holdMax);
        model_t n;
        bit     go;
        bit     kept;
        int     sel;
        int     idx;
        n    = s;
        go   = (s.cnt != 0) && (req != 4'b0000);
        kept = s.acked && (((req >> s.owner) & 4'b0001) != 4'b0000) && (s.hold < holdMax);
        sel  = 0;
        if (kept) begin
            sel = s.owner;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = (s.ptr + k) % 4;
                if (((req >> idx) & 4'b0001) != 4'b0000) sel = idx;
            end
        end
        n.acked   = go;
        n.ackIdx  = sel;
        n.pending = (req != 4'b0000);
        if (ret && s.cnt == credits) n.err = 1'b1;
        n.cnt = s.cnt - (go ? 1 : 0) + ((ret && s.cnt != credits) ? 1 : 0);
        if (go) begin
            if (kept) begin
                n.hold = s.hold + 1;
            end else begin
                n.owner = sel;
                n.hold  = 1;
                n.ptr   = (sel + 1) % 4;
            end
        end
        return n;
    endfunction

    function automatic int modelAck(model_t s);
        return s.acked ? (1 << s.ackIdx) : 0;
    endfunction

    // Models advance on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        if (rst) begin
            mA = modelReset(4);
            mB = modelReset(16);
        end else begin
            mA = modelStep(mA, reqDrive, retDrive, 4, 8);
            mB = modelStep(mB, reqDrive, retDrive, 16, 2);
        end
    end

    task automatic checkOutput(string name, int actual, int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Hand-computed value pinned on both the DUT and the model.
    task automatic pin(string name, int dutVal, int modelVal, int lit);
        checkOutput({name, " dut"}, dutVal, lit);
        checkOutput({name, " model"}, modelVal, lit);
    endtask

    task automatic compareModels();
        checkOutput("A ack",      int'(busA.ack),        modelAck(mA));
        checkOutput("A cnt",      int'(busA.credit_cnt), mA.cnt);
        checkOutput("A busy",     int'(busA.busy),       int'(mA.pending));
        checkOutput("A cred_err", int'(busA.cred_err),   int'(mA.err));
        checkOutput("A onehot",   int'($onehot0(busA.ack)), 1);
        checkOutput("B ack",      int'(busB.ack),        modelAck(mB));
        checkOutput("B cnt",      int'(busB.credit_cnt), mB.cnt);
        checkOutput("B busy",     int'(busB.busy),       int'(mB.pending));
        checkOutput("B cred_err", int'(busB.cred_err),   int'(mB.err));
        checkOutput("B onehot",   int'($onehot0(busB.ack)), 1);
    endtask

    task automatic tick();
        @(negedge clk);
        compareModels();
    endtask

    task automatic applyStimulus(logic [3:0] req, logic ret, logic rstVal);
        reqDrive = req;
        retDrive = ret;
        rst      = rstVal;
    endtask

    task automatic resetDut();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        int bEx[8];
        int r;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        @(negedge clk);

        // Reset state, then one leaf draining the pool until it stalls.
        resetDut();
        pin("reset ack",  int'(busA.ack),        modelAck(mA),     0);
        pin("reset cnt",  int'(busA.credit_cnt), mA.cnt,           4);
        pin("reset busy", int'(busA.busy),       int'(mA.pending), 0);
        pin("reset err",  int'(busA.cred_err),   int'(mA.err),     0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            pin("drain ack", int'(busA.ack),        modelAck(mA), 4);
            pin("drain cnt", int'(busA.credit_cnt), mA.cnt,       4 - k);
        end
        tick();
        pin("stall ack",  int'(busA.ack),        modelAck(mA),     0);
        pin("stall cnt",  int'(busA.credit_cnt), mA.cnt,           0);
        pin("stall busy", int'(busA.busy),       int'(mA.pending), 1);

        // One returned credit gives one ack pulse two cycles later.
        applyStimulus(4'b0100, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        pin("ret ack0", int'(busA.ack),        modelAck(mA), 0);
        pin("ret cnt0", int'(busA.credit_cnt), mA.cnt,       1);
        tick();
        pin("ret ack1", int'(busA.ack),        modelAck(mA), 4);
        pin("ret cnt1", int'(busA.credit_cnt), mA.cnt,       0);
        tick();
        pin("ret ack2", int'(busA.ack),        modelAck(mA), 0);

        // Hold of two alternating between leaves 0 and 1.
        resetDut();
        bEx = '{1, 1, 2, 2, 1, 1, 2, 2};
        applyStimulus(4'b0011, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            pin("hold ack", int'(busB.ack), modelAck(mB), bEx[i]);
        end

        // Pointer at 3, then the pointer wraps to leaf 0 after the hold.
        resetDut();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        tick();
        pin("wrap ack0", int'(busB.ack), modelAck(mB), 4);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick();
        pin("wrap ack1", int'(busB.ack), modelAck(mB), 8);
        applyStimulus(4'b1001, 1'b0, 1'b0);
        tick();
        pin("wrap ack2", int'(busB.ack), modelAck(mB), 8);
        tick();
        pin("wrap ack3", int'(busB.ack), modelAck(mB), 1);

        // Simultaneous grant and return, then overflow into a full pool.
        resetDut();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        tick();
        tick();
        pin("pre cnt", int'(busA.credit_cnt), mA.cnt, 2);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        tick();
        pin("same cnt", int'(busA.credit_cnt), mA.cnt,       2);
        pin("same ack", int'(busA.ack),        modelAck(mA), 1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        pin("fill cnt3", int'(busA.credit_cnt), mA.cnt, 3);
        tick();
        pin("fill cnt4", int'(busA.credit_cnt), mA.cnt,     4);
        pin("fill err0", int'(busA.cred_err),   int'(mA.err), 0);
        tick();
        pin("over cnt", int'(busA.credit_cnt), mA.cnt,       4);
        pin("over err", int'(busA.cred_err),   int'(mA.err), 1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        pin("sticky err", int'(busA.cred_err), int'(mA.err), 1);
        resetDut();
        pin("clear err", int'(busA.cred_err), int'(mA.err), 0);

        // Reset in the middle of a grant.
        applyStimulus(4'b0010, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        pin("mid ack", int'(busA.ack),        modelAck(mA), 2);
        pin("mid cnt", int'(busA.credit_cnt), mA.cnt,       1);
        applyStimulus(4'b0010, 1'b0, 1'b1);
        tick();
        pin("rst ack",  int'(busA.ack),        modelAck(mA),     0);
        pin("rst cnt",  int'(busA.credit_cnt), mA.cnt,           4);
        pin("rst busy", int'(busA.busy),       int'(mA.pending), 0);

        // Random leaf traffic with returns and the occasional reset.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 1) == 0) reqDrive = 4'($urandom_range(0, 15));
            retDrive = ($urandom_range(0, 99) < 40);
            rst      = (r < 2);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
